rom_stream_reader: RTL and testbench
====================================

Name: rom_stream_reader

Overview:
Upstream sequencer for the 16x16 ROM (1-cycle registered read, data held while r_en low). Accepts a burst command (start address, beat count) and drives the ROM addr/r_en. Returns ROM words as a valid/ready stream with last-beat marking. Absorbs ROM read latency and downstream backpressure in a 2-entry output buffer.

Parameters:
DATA_W, 16, ROM word width
ADDR_W, 4, ROM address width; depth = 2**ADDR_W

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  command strobe, sampled only in IDLE
start_addr  input  ADDR_W  first ROM address of burst
count  input  ADDR_W+1  beats in burst, 0..16
rom_r_en  output  1  ROM read enable
rom_addr  output  ADDR_W  ROM address
rom_data  input  DATA_W  ROM read data (valid cycle after rom_r_en=1)
out_valid  output  1  stream beat valid
out_data  output  DATA_W  stream beat data
out_last  output  1  final beat of burst (qualified by out_valid)
out_ready  input  1  downstream accept
busy  output  1  high from cycle after accepted start until done
done  output  1  one-cycle pulse on burst completion

Behaviour:
- Reset (async, rst_n=0): state IDLE; rom_r_en=0, rom_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0; buffer empty, in-flight flag clear, counters 0. Reset mid-burst aborts immediately; no beats after release until a new start.
- States: IDLE, READ, FLUSH.
- IDLE: start=1 & count!=0 -> latch addr/issue counter/remaining-beat counter = count, go READ, busy=1 next cycle. start=1 & count=0 -> done=1 next cycle, no ROM read, stay IDLE, busy stays 0.
- READ: rom_r_en=1 when issue credit available: (buffer occupancy + in_flight) < 2, or a stream handshake (out_valid & out_ready) occurs this cycle. Otherwise rom_r_en=0. rom_addr = current issue address.
- Each issued read: address increments mod 2**ADDR_W (15 -> 0 wrap), issue counter decrements. Issue counter reaches 0 -> FLUSH.
- in_flight set on cycle after rom_r_en=1; that cycle rom_data written into buffer (tail). Buffer never overflows by the credit rule.
- out_valid = buffer non-empty; out_data/out_last from buffer head, all registered. Beat consumed on out_valid & out_ready. out_data and out_last stable while out_valid=1 & out_ready=0.
- out_last=1 only on the beat whose remaining-beat count = 1 when written.
- FLUSH: no reads; last beat consumed -> done=1 next cycle, busy=0, IDLE.
- Latency: start at edge E0 -> rom_r_en=1 after E0 -> first out_valid=1 after E2. With out_ready held 1: one beat per cycle, no bubbles; N-beat burst: done pulses 1 cycle after final handshake.
- start while busy ignored (no state/command change).
- Simultaneous push and pop on one edge: occupancy unchanged, order preserved.

Test Plan:
- ROM loaded 0103,5200,e0b9,0412,4839,0112,0377,0572,cafe,6225,1447,aeec,52dd,1113,4444,5555; start_addr=0, count=16, out_ready=1 -> 16 consecutive beats 0103..5555, out_last only on 5555, first out_valid 2 cycles after start, done 1 cycle after last beat.
- Wrap: start_addr=14, count=4 -> beats 4444,5555,0103,5200; rom_addr sequence 14,15,0,1; out_last on 5200.
- Backpressure: start_addr=8, count=3, out_ready=0 for 6 cycles then 1 -> exactly 2 reads issued, then rom_r_en=0; out_data holds cafe stably; after release beats cafe,6225,1447, no loss or duplication.
- count=0 -> done pulse 1 cycle after start, rom_r_en never 1, out_valid stays 0, busy stays 0.
- start pulsed again mid-burst with start_addr=3, count=2 -> ignored; original burst completes unchanged.
- rst_n low mid-burst (after 2 beats of 16) -> all outputs 0 immediately; after release no beats until new start; new start_addr=5, count=1 -> single beat 0112 with out_last=1.

Source files
------------

// File: rtl/rom_stream_reader_if.sv
// Command, ROM-side and output-stream signals of the ROM burst reader.
// master: the reader itself; slave: the surrounding environment.
interface rom_stream_reader_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   count;
  logic              rom_r_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, start_addr, count, rom_data, out_ready,
    output rom_r_en, rom_addr, out_valid, out_data, out_last, busy, done
  );

  modport slave (
    output start, start_addr, count, rom_data, out_ready,
    input  rom_r_en, rom_addr, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/rom_stream_reader.sv
// Burst sequencer for a 1-cycle registered ROM. Issues reads under a 2-credit
// scheme and returns the words as a valid/ready stream through a 2-entry buffer.
module rom_stream_reader #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  rom_stream_reader_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRead, StFlush} state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_issue_cnt;
  logic [ADDR_W:0]   r_rem_cnt;
  logic              r_in_flight;
  logic              r_busy;
  logic              r_done;
  // Entry 0 is always the head, so the stream outputs come straight from flops.
  logic [DATA_W-1:0] r_buf_data [2];
  logic [1:0]        r_buf_last;
  logic [1:0]        r_occ;

  logic       w_pop;
  logic       w_push;
  logic       w_push_last;
  logic       w_issue;
  logic [2:0] w_credit_used;
  logic       w_wr_idx;

  assign w_pop         = (r_occ != 2'd0) & bus.out_ready;
  assign w_push        = r_in_flight;
  assign w_push_last   = (r_rem_cnt == (ADDR_W + 1)'(1));
  assign w_credit_used = {1'b0, r_occ} + {2'b00, r_in_flight};
  // A handshake this cycle frees a slot in time for the word returning next cycle.
  assign w_issue       = (r_state == StRead) & ((w_credit_used < 3'd2) | w_pop);
  // Write slot accounts for the head leaving on the same edge.
  assign w_wr_idx      = ((r_occ - 2'(w_pop)) != 2'd0);

  assign bus.rom_r_en  = w_issue;
  assign bus.rom_addr  = r_addr;
  assign bus.out_valid = (r_occ != 2'd0);
  assign bus.out_data  = r_buf_data[0];
  assign bus.out_last  = r_buf_last[0];
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

  // Command FSM: latches bursts, advances the issue address, signals completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_issue_cnt <= '0;
      r_rem_cnt   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_push) r_rem_cnt <= r_rem_cnt - (ADDR_W + 1)'(1);
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            if (bus.count != '0) begin
              r_addr      <= bus.start_addr;
              r_issue_cnt <= bus.count;
              r_rem_cnt   <= bus.count;
              r_busy      <= 1'b1;
              r_state     <= StRead;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        StRead: begin
          if (w_issue) begin
            r_addr      <= r_addr + ADDR_W'(1);
            r_issue_cnt <= r_issue_cnt - (ADDR_W + 1)'(1);
            if (r_issue_cnt == (ADDR_W + 1)'(1)) r_state <= StFlush;
          end
        end
        StFlush: begin
          if (w_pop && r_buf_last[0]) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Read-in-flight tracker plus the 2-entry output buffer (shift-on-pop).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_flight <= 1'b0;
      r_occ       <= 2'd0;
      r_buf_last  <= 2'b00;
      for (int i = 0; i < 2; i++) r_buf_data[i] <= '0;
    end else begin
      r_in_flight <= w_issue;
      if (w_pop) begin
        r_buf_data[0] <= r_buf_data[1];
        r_buf_last[0] <= r_buf_last[1];
      end
      if (w_push) begin
        r_buf_data[w_wr_idx] <= bus.rom_data;
        r_buf_last[w_wr_idx] <= w_push_last;
      end
      r_occ <= r_occ + 2'(w_push) - 2'(w_pop);
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader with a behavioural ROM.
module tb_rom_stream_reader;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rom_stream_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rom_stream_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [15:0] mem [16];
  logic [15:0] rom_q;
  initial begin
    mem[0]  = 16'h0103; mem[1]  = 16'h5200; mem[2]  = 16'he0b9; mem[3]  = 16'h0412;
    mem[4]  = 16'h4839; mem[5]  = 16'h0112; mem[6]  = 16'h0377; mem[7]  = 16'h0572;
    mem[8]  = 16'hcafe; mem[9]  = 16'h6225; mem[10] = 16'h1447; mem[11] = 16'haeec;
    mem[12] = 16'h52dd; mem[13] = 16'h1113; mem[14] = 16'h4444; mem[15] = 16'h5555;
  end
  always_ff @(posedge clk) if (bus.rom_r_en) rom_q <= mem[bus.rom_addr];
  assign bus.rom_data = rom_q;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q [$];   // {last, data}
  int rd_cnt = 0;
  int beats = 0;
  int addr_log [$];
  logic model_busy = 1'b0;
  logic hold_prev = 1'b0;
  logic [16:0] hold_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each handshake beat against the scoreboard, checks hold stability.
  always @(negedge clk) begin
    if (bus.rom_r_en) begin
      rd_cnt++;
      addr_log.push_back(int'(bus.rom_addr));
    end
    if (rst_n && hold_prev && bus.out_valid)
      check("hold stable", {15'd0, bus.out_last, bus.out_data}, {15'd0, hold_val});
    hold_prev = rst_n && bus.out_valid && !bus.out_ready;
    hold_val  = {bus.out_last, bus.out_data};
    if (rst_n && bus.out_valid && bus.out_ready) begin
      beats++;
      if (exp_q.size() == 0) check("unexpected beat", 32'(bus.out_data), 32'hdead_0000);
      else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("beat data", 32'(bus.out_data), 32'(e[15:0]));
        check("beat last", 32'(bus.out_last), 32'(e[16]));
      end
    end
  end

  // Drives one start pulse; the model queues the burst only if the DUT should be idle.
  task automatic do_start(input int a, input int c);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.start_addr = 4'(a);
    bus.count = 5'(c);
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (!model_busy && c != 0) begin
      model_busy = 1'b1;
      for (int i = 0; i < c; i++)
        exp_q.push_back({(i == c - 1), mem[(a + i) % 16]});
    end
  endtask

  task automatic wait_done(input bit rnd, output int n);
    n = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      n++;
      if (bus.done) break;
      if (rnd) begin
        @(posedge clk); #1;
        bus.out_ready = 1'($urandom_range(0, 1));
      end
    end
    if (!bus.done) check("done timeout", 32'd0, 32'd1);
    model_busy = 1'b0;
    @(negedge clk);
    check("done one pulse", 32'(bus.done), 32'd0);
    check("busy after done", 32'(bus.busy), 32'd0);
    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    int n, r0, b0;
    bus.start = 1'b0; bus.start_addr = '0; bus.count = '0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset outputs", {25'd0, bus.rom_r_en, bus.rom_addr, bus.out_valid, bus.busy, bus.done},
          32'd0);
    check("reset data", {15'd0, bus.out_last, bus.out_data}, 32'd0);
    rst_n = 1'b1;

    // Full ROM burst with latency and throughput checks.
    do_start(0, 16);
    @(negedge clk);
    check("first r_en", 32'(bus.rom_r_en), 32'd1);
    check("busy set", 32'(bus.busy), 32'd1);
    check("no early valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("no valid E1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("valid E2", 32'(bus.out_valid), 32'd1);
    check("first data", 32'(bus.out_data), 32'h0103);
    wait_done(1'b0, n);
    check("no bubbles", 32'(n), 32'd16);

    // Address wrap.
    addr_log.delete();
    do_start(14, 4);
    wait_done(1'b0, n);
    check("wrap reads", 32'(addr_log.size()), 32'd4);
    if (addr_log.size() == 4)
      check("wrap addrs", {addr_log[0][7:0], addr_log[1][7:0], addr_log[2][7:0], addr_log[3][7:0]},
            32'h0e0f0001);

    // Backpressure.
    bus.out_ready = 1'b0;
    r0 = rd_cnt;
    do_start(8, 3);
    repeat (6) @(negedge clk);
    #1;
    check("bp reads", 32'(rd_cnt - r0), 32'd2);
    check("bp r_en low", 32'(bus.rom_r_en), 32'd0);
    check("bp head", 32'(bus.out_data), 32'hcafe);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_done(1'b0, n);
    check("bp total reads", 32'(rd_cnt - r0), 32'd3);

    // Zero-length command.
    r0 = rd_cnt; b0 = beats;
    do_start(7, 0);
    @(negedge clk);
    check("zero done", 32'(bus.done), 32'd1);
    check("zero busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("zero done pulse", 32'(bus.done), 32'd0);
    repeat (3) @(negedge clk);
    check("zero no reads", 32'(rd_cnt - r0), 32'd0);
    check("zero no beats", 32'(beats - b0), 32'd0);

    // Start while busy is ignored.
    r0 = rd_cnt;
    do_start(6, 5);
    do_start(3, 2);
    wait_done(1'b0, n);
    repeat (4) @(negedge clk);
    check("ignored start reads", 32'(rd_cnt - r0), 32'd5);

    // Reset mid-burst.
    b0 = beats;
    do_start(0, 16);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #1;
      if (beats >= b0 + 2) break;
    end
    rst_n = 1'b0;
    #1;
    check("rst outputs", {25'd0, bus.rom_r_en, bus.rom_addr, bus.out_valid, bus.busy, bus.done},
          32'd0);
    check("rst data", {15'd0, bus.out_last, bus.out_data}, 32'd0);
    exp_q.delete();
    model_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r0 = rd_cnt; b0 = beats;
    repeat (5) @(negedge clk);
    check("post rst quiet", 32'(rd_cnt - r0 + beats - b0), 32'd0);
    do_start(5, 1);
    wait_done(1'b0, n);
    check("single beat", 32'(beats - b0), 32'd1);

    // Randomized bursts under random backpressure.
    for (int t = 0; t < 10; t++) begin
      b0 = beats;
      n = int'($urandom_range(1, 16));
      do_start(int'($urandom_range(0, 15)), n);
      r0 = n;
      wait_done(1'b1, n);
      check("rand beats", 32'(beats - b0), 32'(r0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end
endmodule
